// File: rtl/dcache_mshr_ctrl.sv
// Non-blocking data-cache miss controller with NUM_MSHR miss status holding registers.
// Define DCACHE_MSHR_MERGE_EN to merge secondary misses into an in-flight entry.
module dcache_mshr_ctrl #(
    parameter  int NUM_MSHR   = 4,
    parameter  int INDEX_BITS = 5,
    localparam int ID_W       = $clog2(NUM_MSHR),
    localparam int TAG_BITS   = 29 - INDEX_BITS
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  miss_valid_i,
    input  logic [31:0]           miss_addr_i,
    output logic                  miss_ready_o,
    output logic [ID_W-1:0]       miss_id_o,
    input  logic                  squash_i,
    output logic [1:0]            proc2Dmem_command_o,
    output logic [31:0]           proc2Dmem_addr_o,
    input  logic [3:0]            Dmem2proc_response_i,
    input  logic [63:0]           Dmem2proc_data_i,
    input  logic [3:0]            Dmem2proc_tag_i,
    output logic                  fill_valid_o,
    output logic [INDEX_BITS-1:0] fill_index_o,
    output logic [TAG_BITS-1:0]   fill_tag_o,
    output logic [63:0]           fill_data_o,
    output logic                  wake_valid_o,
    output logic [ID_W-1:0]       wake_id_o,
    output logic [ID_W:0]         mshr_busy_o
);

    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    typedef enum logic [1:0] {S_FREE, S_PEND, S_WAIT} state_e;

    state_e      state_q    [NUM_MSHR];
    state_e      state_d    [NUM_MSHR];
    logic [28:0] line_q     [NUM_MSHR];
    logic [28:0] line_d     [NUM_MSHR];
    logic [3:0]  mem_tag_q  [NUM_MSHR];
    logic [3:0]  mem_tag_d  [NUM_MSHR];
    logic        squashed_q [NUM_MSHR];
    logic        squashed_d [NUM_MSHR];

    logic [28:0]   miss_line;
    logic          fill_hit, iss_valid, free_any, hit_any, collide, accept_ok, alloc;
    logic [ID_W-1:0] fill_sel, iss_sel, free_sel, hit_sel;
    logic [ID_W:0] busy_cnt;
    logic          unused_addr_bits;

    assign miss_line        = miss_addr_i[31:3];
    assign unused_addr_bits = ^miss_addr_i[2:0];

    // Descending scan so the lowest matching index wins each priority pick.
    always_comb begin
        fill_hit = 1'b0;
        fill_sel = '0;
        iss_valid = 1'b0;
        iss_sel  = '0;
        free_any = 1'b0;
        free_sel = '0;
        hit_any  = 1'b0;
        hit_sel  = '0;
        busy_cnt = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (state_q[i] == S_WAIT && Dmem2proc_tag_i != 4'd0 &&
                mem_tag_q[i] == Dmem2proc_tag_i) begin
                fill_hit = 1'b1;
                fill_sel = ID_W'(i);
            end
            if (state_q[i] == S_PEND) begin
                iss_valid = 1'b1;
                iss_sel   = ID_W'(i);
            end
            if (state_q[i] == S_FREE) begin
                free_any = 1'b1;
                free_sel = ID_W'(i);
            end else begin
                busy_cnt = busy_cnt + (ID_W+1)'(1);
                if (line_q[i] == miss_line) begin
                    hit_any = 1'b1;
                    hit_sel = ID_W'(i);
                end
            end
        end
    end

    assign collide = fill_hit && (line_q[fill_sel] == miss_line);

    always_comb begin
`ifdef DCACHE_MSHR_MERGE_EN
        accept_ok = hit_any | free_any;
        miss_id_o = hit_any ? hit_sel : free_sel;
        alloc     = miss_valid_i & miss_ready_o & ~hit_any;
`else
        accept_ok = ~hit_any & free_any;
        miss_id_o = free_sel;
        alloc     = miss_valid_i & miss_ready_o;
`endif
    end

    assign miss_ready_o = ~squash_i & ~collide & accept_ok;

    // Squash gates issue so a PEND entry being flushed never reaches the bus.
    assign proc2Dmem_command_o = (iss_valid && !squash_i) ? BUS_LOAD : BUS_NONE;
    assign proc2Dmem_addr_o    = (iss_valid && !squash_i) ? {line_q[iss_sel], 3'b000} : 32'd0;

    assign fill_valid_o = fill_hit;
    assign fill_index_o = fill_hit ? line_q[fill_sel][INDEX_BITS-1:0] : '0;
    assign fill_tag_o   = fill_hit ? line_q[fill_sel][28:INDEX_BITS] : '0;
    assign fill_data_o  = Dmem2proc_data_i;
    assign wake_valid_o = fill_hit & ~squashed_q[fill_sel];
    assign wake_id_o    = fill_sel;
    assign mshr_busy_o  = busy_cnt;

    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            state_d[i]    = state_q[i];
            line_d[i]     = line_q[i];
            mem_tag_d[i]  = mem_tag_q[i];
            squashed_d[i] = squashed_q[i];
            if (fill_hit && fill_sel == ID_W'(i)) begin
                state_d[i]    = S_FREE;
                squashed_d[i] = 1'b0;
            end else if (squash_i && state_q[i] == S_PEND) begin
                state_d[i] = S_FREE;
            end else if (squash_i && state_q[i] == S_WAIT) begin
                squashed_d[i] = 1'b1;
            end else if (proc2Dmem_command_o == BUS_LOAD && iss_sel == ID_W'(i) &&
                         Dmem2proc_response_i != 4'd0) begin
                state_d[i]   = S_WAIT;
                mem_tag_d[i] = Dmem2proc_response_i;
            end else if (alloc && free_sel == ID_W'(i)) begin
                state_d[i]    = S_PEND;
                line_d[i]     = miss_line;
                squashed_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_q[i]    <= S_FREE;
                line_q[i]     <= '0;
                mem_tag_q[i]  <= '0;
                squashed_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_q[i]    <= state_d[i];
                line_q[i]     <= line_d[i];
                mem_tag_q[i]  <= mem_tag_d[i];
                squashed_q[i] <= squashed_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed bench for dcache_mshr_ctrl: single miss, full, retry, out-of-order, squash, merge.
module tb_dcache_mshr_ctrl;

    localparam int NUM_MSHR   = 4;
    localparam int INDEX_BITS = 5;
    localparam int ID_W       = 2;
    localparam int TAG_BITS   = 24;
    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  miss_valid;
    logic [31:0]           miss_addr;
    logic                  miss_ready;
    logic [ID_W-1:0]       miss_id;
    logic                  squash;
    logic [1:0]            cmd;
    logic [31:0]           bus_addr;
    logic [3:0]            response;
    logic [63:0]           mem_data;
    logic [3:0]            mem_tag;
    logic                  fill_valid;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [63:0]           fill_data;
    logic                  wake_valid;
    logic [ID_W-1:0]       wake_id;
    logic [ID_W:0]         busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    dcache_mshr_ctrl #(.NUM_MSHR(NUM_MSHR), .INDEX_BITS(INDEX_BITS)) dut (
        .clock_i              (clock),
        .reset_i              (reset),
        .miss_valid_i         (miss_valid),
        .miss_addr_i          (miss_addr),
        .miss_ready_o         (miss_ready),
        .miss_id_o            (miss_id),
        .squash_i             (squash),
        .proc2Dmem_command_o  (cmd),
        .proc2Dmem_addr_o     (bus_addr),
        .Dmem2proc_response_i (response),
        .Dmem2proc_data_i     (mem_data),
        .Dmem2proc_tag_i      (mem_tag),
        .fill_valid_o         (fill_valid),
        .fill_index_o         (fill_index),
        .fill_tag_o           (fill_tag),
        .fill_data_o          (fill_data),
        .wake_valid_o         (wake_valid),
        .wake_id_o            (wake_id),
        .mshr_busy_o          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        miss_valid = 1'b0;
        miss_addr  = 32'd0;
        squash     = 1'b0;
        response   = 4'd0;
        mem_data   = 64'd0;
        mem_tag    = 4'd0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    logic [31:0] full_addr [4];

    initial begin
        full_addr[0] = 32'h0000_0100;
        full_addr[1] = 32'h0000_0200;
        full_addr[2] = 32'h0000_0300;
        full_addr[3] = 32'h0000_0400;

        // Reset state
        idle();
        reset = 1'b1;
        #2;
        check("rst_ready", miss_ready, 1);
        check("rst_id", miss_id, 0);
        check("rst_cmd", cmd, BUS_NONE);
        check("rst_addr", bus_addr, 0);
        check("rst_fill", fill_valid, 0);
        check("rst_wake", wake_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Single miss
        miss_valid = 1'b1; miss_addr = 32'h0000_1008;
        #1;
        check("s1_ready", miss_ready, 1);
        check("s1_id", miss_id, 0);
        check("s1_no_comb_issue", cmd, BUS_NONE);
        tick();
        miss_valid = 1'b0; response = 4'd3;
        #1;
        check("s1_cmd", cmd, BUS_LOAD);
        check("s1_addr", bus_addr, 32'h0000_1008);
        check("s1_busy1", busy, 1);
        tick();
        response = 4'd0;
        #1;
        check("s1_wait_cmd", cmd, BUS_NONE);
        tick();
        mem_tag = 4'd3; mem_data = 64'hDEAD_BEEF_0000_1008;
        #1;
        check("s1_fill", fill_valid, 1);
        check("s1_fidx", fill_index, 5'h01);
        check("s1_ftag", fill_tag, 24'h10);
        check("s1_fdata", fill_data, 64'hDEAD_BEEF_0000_1008);
        check("s1_wake", wake_valid, 1);
        check("s1_wake_id", wake_id, 0);
        check("s1_busy_fill", busy, 1);
        tick();
        mem_tag = 4'd0;
        #1;
        check("s1_busy0", busy, 0);
        check("s1_fill_off", fill_valid, 0);

        // Full
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            miss_valid = 1'b1; miss_addr = full_addr[k];
            response = (k > 0) ? 4'(k) : 4'd0;
            #1;
            check("full_ready", miss_ready, 1);
            check("full_id", miss_id, 64'(k));
            if (k > 0) begin
                check("full_cmd", cmd, BUS_LOAD);
                check("full_addr", bus_addr, full_addr[k-1]);
            end
            tick();
        end
        miss_addr = 32'h0000_0500; response = 4'd4;
        #1;
        check("full_stall", miss_ready, 0);
        check("full_busy4", busy, 4);
        check("full_last_addr", bus_addr, 32'h0000_0400);
        tick();
        response = 4'd0; mem_tag = 4'd2; mem_data = 64'h2222;
        #1;
        check("full_stall_fill", miss_ready, 0);
        check("full_fill", fill_valid, 1);
        check("full_wake_id", wake_id, 1);
        tick();
        mem_tag = 4'd0;
        #1;
        check("full_realloc_ready", miss_ready, 1);
        check("full_realloc_id", miss_id, 1);
        tick();
        miss_valid = 1'b0;
        #1;
        check("full_busy_again", busy, 4);
        check("full_new_cmd", cmd, BUS_LOAD);
        check("full_new_addr", bus_addr, 32'h0000_0500);

        // Reset mid-operation drops outstanding tags
        apply_reset();
        mem_tag = 4'd3;
        #1;
        check("midrst_fill", fill_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd", cmd, BUS_NONE);
        mem_tag = 4'd0;

        // Reject / retry
        tick();
        miss_valid = 1'b1; miss_addr = 32'h0000_3000;
        #1;
        check("retry_ready", miss_ready, 1);
        tick();
        miss_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            response = (c == 3) ? 4'd5 : 4'd0;
            #1;
            check("retry_cmd", cmd, BUS_LOAD);
            check("retry_addr", bus_addr, 32'h0000_3000);
            tick();
        end
        response = 4'd0;
        #1;
        check("retry_done", cmd, BUS_NONE);
        check("retry_busy", busy, 1);

        // Out-of-order return
        apply_reset();
        miss_valid = 1'b1; miss_addr = 32'h0000_4000;
        #1;
        tick();
        miss_addr = 32'h0000_4100; response = 4'd7;
        #1;
        check("ooo_id1", miss_id, 1);
        tick();
        miss_valid = 1'b0; response = 4'd8;
        #1;
        check("ooo_issue1", bus_addr, 32'h0000_4100);
        tick();
        response = 4'd0; mem_tag = 4'd8; mem_data = 64'h8888_0000_8888_0001;
        #1;
        check("ooo_fill8", fill_valid, 1);
        check("ooo_wake8", wake_valid, 1);
        check("ooo_wid8", wake_id, 1);
        check("ooo_data8", fill_data, 64'h8888_0000_8888_0001);
        check("ooo_ftag8", fill_tag, 24'h41);
        check("ooo_fidx8", fill_index, 5'h00);
        tick();
        mem_tag = 4'd7; mem_data = 64'h7777_0000_7777_0002;
        #1;
        check("ooo_wid7", wake_id, 0);
        check("ooo_data7", fill_data, 64'h7777_0000_7777_0002);
        check("ooo_ftag7", fill_tag, 24'h40);
        tick();
        mem_tag = 4'd0;
        #1;
        check("ooo_busy0", busy, 0);

        // Squash
        apply_reset();
        miss_valid = 1'b1; miss_addr = 32'h0000_5000;
        #1;
        tick();
        miss_addr = 32'h0000_5100; response = 4'd6;
        #1;
        tick();
        miss_addr = 32'h0000_5200; squash = 1'b1; response = 4'd9;
        #1;
        check("sq_ready", miss_ready, 0);
        check("sq_cmd", cmd, BUS_NONE);
        check("sq_busy2", busy, 2);
        tick();
        squash = 1'b0; miss_valid = 1'b0; response = 4'd0;
        #1;
        check("sq_busy1", busy, 1);
        check("sq_no_issue", cmd, BUS_NONE);
        tick();
        check("sq_no_issue2", cmd, BUS_NONE);
        mem_tag = 4'd6;
        #1;
        check("sq_fill", fill_valid, 1);
        check("sq_nowake", wake_valid, 0);
        check("sq_ftag", fill_tag, 24'h50);
        tick();
        mem_tag = 4'd9;
        #1;
        check("sq_tag9_none", fill_valid, 0);
        check("sq_busy0", busy, 0);
        mem_tag = 4'd0;
        tick();

        // Merge / duplicate line
        apply_reset();
        miss_valid = 1'b1; miss_addr = 32'h0000_2000;
        #1;
        check("mg_first_id", miss_id, 0);
        tick();
        response = 4'd10;
        #1;
`ifdef DCACHE_MSHR_MERGE_EN
        check("mg_ready", miss_ready, 1);
        check("mg_id", miss_id, 0);
        tick();
        miss_valid = 1'b0; response = 4'd0;
        #1;
        check("mg_busy", busy, 1);
        check("mg_one_load", cmd, BUS_NONE);
        tick();
        miss_valid = 1'b1; mem_tag = 4'd10;
        #1;
        check("mg_fill", fill_valid, 1);
        check("mg_collide", miss_ready, 0);
        tick();
        mem_tag = 4'd0;
        #1;
        check("mg_busy0", busy, 0);
        check("mg_realloc_ready", miss_ready, 1);
        check("mg_realloc_id", miss_id, 0);
`else
        check("dup_stall_pend", miss_ready, 0);
        tick();
        response = 4'd0;
        #1;
        check("dup_stall_wait", miss_ready, 0);
        check("dup_busy", busy, 1);
        tick();
        mem_tag = 4'd10;
        #1;
        check("dup_fill", fill_valid, 1);
        check("dup_collide", miss_ready, 0);
        check("dup_wake_id", wake_id, 0);
        tick();
        mem_tag = 4'd0;
        #1;
        check("dup_ready", miss_ready, 1);
        check("dup_id", miss_id, 0);
        tick();
        miss_valid = 1'b0;
        #1;
        check("dup_busy_again", busy, 1);
        check("dup_reissue", bus_addr, 32'h0000_2000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
